// File: rtl/ser2par_pkg.sv
// Shared types and helpers for the serial-to-parallel stream packer.
package ser2par_pkg;

  typedef enum logic {
    LSB_FIRST_E = 1'b0,
    MSB_FIRST_E = 1'b1
  } ser2par_order_e;

  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  // Lowest accumulator bit occupied by beat index k.
  function automatic int slot_lsb(input int k, input int ratio, input int in_w,
                                  input ser2par_order_e order);
    if (order == MSB_FIRST_E) begin
      return (ratio - 1 - k) * in_w;
    end else begin
      return k * in_w;
    end
  endfunction

endpackage

// File: rtl/ser2par_out_reg.sv
// Output holding register: word/keep/last (and parity with SER2PAR_PARITY_EN)
// held stable under backpressure, released on out_ready.
module ser2par_out_reg #(
  parameter int OUT_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
  input  logic [CNT_W-1:0] load_keep,
  input  logic             load_last,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_keep,
  output logic             out_last
`ifdef SER2PAR_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  logic             valid_r, valid_nxt_s;
  logic [OUT_W-1:0] data_r, data_nxt_s;
  logic [CNT_W-1:0] keep_r, keep_nxt_s;
  logic             last_r, last_nxt_s;
`ifdef SER2PAR_PARITY_EN
  logic             parity_r, parity_nxt_s;

  // Unfilled slots are zero, so the XOR of the whole word covers only valid beats.
  function automatic logic even_parity(input logic [OUT_W-1:0] word);
    return ^word;
  endfunction
`endif

  assign in_ready = ~valid_r | out_ready;

  // Load a completed word, drop it once consumed, otherwise hold.
  always_comb begin
    valid_nxt_s = valid_r;
    data_nxt_s  = data_r;
    keep_nxt_s  = keep_r;
    last_nxt_s  = last_r;
`ifdef SER2PAR_PARITY_EN
    parity_nxt_s = parity_r;
`endif
    if (load) begin
      valid_nxt_s = 1'b1;
      data_nxt_s  = load_data;
      keep_nxt_s  = load_keep;
      last_nxt_s  = load_last;
`ifdef SER2PAR_PARITY_EN
      parity_nxt_s = even_parity(load_data);
`endif
    end else if (out_ready) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end
  end

  // Output state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      data_r  <= {OUT_W{1'b0}};
      keep_r  <= {CNT_W{1'b0}};
      last_r  <= 1'b0;
`ifdef SER2PAR_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      valid_r <= valid_nxt_s;
      data_r  <= data_nxt_s;
      keep_r  <= keep_nxt_s;
      last_r  <= last_nxt_s;
`ifdef SER2PAR_PARITY_EN
      parity_r <= parity_nxt_s;
`endif
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_keep  = keep_r;
  assign out_last  = last_r;
`ifdef SER2PAR_PARITY_EN
  assign out_parity = parity_r;
`endif

endmodule

// File: rtl/serial_to_parallel_stream.sv
// Packs IN_W-bit beats into RATIO-beat words with ready/valid on both sides.
// Optional even-parity output enabled by defining SER2PAR_PARITY_EN.
module serial_to_parallel_stream
  import ser2par_pkg::*;
#(
  parameter int IN_W      = 1,
  parameter int RATIO     = 8,
  parameter int MSB_FIRST = 0,
  localparam int OUT_W    = IN_W * RATIO,
  localparam int CNT_W    = cnt_width(RATIO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_keep,
  output logic             out_last
`ifdef SER2PAR_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int IDX_W = $clog2(RATIO);
  localparam ser2par_order_e ORDER = (MSB_FIRST != 0) ? MSB_FIRST_E : LSB_FIRST_E;

  logic [IDX_W-1:0] cnt_r, cnt_nxt_s;
  logic [OUT_W-1:0] acc_r, acc_nxt_s;
  logic [OUT_W-1:0] merged_s;
  logic [CNT_W-1:0] keep_s;
  logic             accept_s;
  logic             last_beat_s;
  logic             complete_s;

  assign accept_s    = in_valid & in_ready;
  assign last_beat_s = in_last | (cnt_r == IDX_W'(RATIO - 1));
  assign complete_s  = accept_s & last_beat_s;
  assign keep_s      = CNT_W'(cnt_r) + CNT_W'(1'b1);

  // Current beat lands in its slot; every other slot keeps the accumulated value.
  for (genvar g = 0; g < RATIO; g++) begin : g_slot
    localparam int LSB = slot_lsb(g, RATIO, IN_W, ORDER);
    assign merged_s[LSB +: IN_W] = (cnt_r == IDX_W'(g)) ? in_data : acc_r[LSB +: IN_W];
  end

  // Counter/accumulator advance on accepted beats and clear on word completion.
  always_comb begin
    cnt_nxt_s = cnt_r;
    acc_nxt_s = acc_r;
    if (complete_s) begin
      cnt_nxt_s = {IDX_W{1'b0}};
      acc_nxt_s = {OUT_W{1'b0}};
    end else if (accept_s) begin
      cnt_nxt_s = cnt_r + IDX_W'(1'b1);
      acc_nxt_s = merged_s;
    end else begin
      cnt_nxt_s = cnt_r;
      acc_nxt_s = acc_r;
    end
  end

  // Beat counter and partial-word accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {IDX_W{1'b0}};
      acc_r <= {OUT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
      acc_r <= acc_nxt_s;
    end
  end

  ser2par_out_reg #(
    .OUT_W(OUT_W),
    .CNT_W(CNT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (complete_s),
    .load_data (merged_s),
    .load_keep (keep_s),
    .load_last (in_last),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last)
`ifdef SER2PAR_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

endmodule
